// File: rtl/uart_spi_bridge.sv
// uart_spi_bridge: buffers UART bytes in a FIFO, sends each over SPI and returns the reply over UART
module uart_spi_bridge #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    uart_rx_data,
  input  logic                          uart_rx_valid,
  output logic [7:0]                    spi_tx_data,
  output logic                          spi_start,
  input  logic                          spi_tx_done,
  input  logic [7:0]                    spi_rx_data,
  output logic [7:0]                    uart_tx_data,
  output logic                          uart_tx_start,
  input  logic                          uart_tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [2:0] {IDLE, SPI_START, SPI_WAIT, UART_WAIT, UART_START, UART_DRAIN} state_t;
  state_t state_q, state_d;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, spi_start_q, spi_start_d, uart_start_q, uart_start_d;
  logic [7:0] spi_data_q, spi_data_d, uart_data_q, uart_data_d;
  logic pop, push, full;
  // FIFO bookkeeping, byte capture and next-state; start pulses are decoded from the next state so they register
  always_comb begin
    full = cnt_q == CW'(FIFO_DEPTH);
    pop = state_q == IDLE && cnt_q != '0;
    push = uart_rx_valid && (!full || pop);
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    ovf_d = ovf_q | (uart_rx_valid & full & ~pop);
    spi_data_d = pop ? mem_q[rd_ptr_q] : spi_data_q;
    uart_data_d = (state_q == SPI_WAIT && spi_tx_done) ? spi_rx_data : uart_data_q;
    state_d = state_q;
    unique case (state_q)
      IDLE:       state_d = pop ? SPI_START : IDLE;
      SPI_START:  state_d = SPI_WAIT;
      SPI_WAIT:   state_d = spi_tx_done ? UART_WAIT : SPI_WAIT;
      UART_WAIT:  state_d = uart_tx_ready ? UART_START : UART_WAIT;
      UART_START: state_d = UART_DRAIN;
      UART_DRAIN: state_d = uart_tx_ready ? UART_DRAIN : IDLE;
      default:    state_d = IDLE;
    endcase
    spi_start_d = state_d == SPI_START;
    uart_start_d = state_d == UART_START;
  end
  // FIFO storage needs no reset: the reset pointers make its contents unreachable
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= uart_rx_data;
  end
  // All control state and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      spi_data_q <= 8'h00;
      uart_data_q <= 8'h00;
      spi_start_q <= 1'b0;
      uart_start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      spi_data_q <= spi_data_d;
      uart_data_q <= uart_data_d;
      spi_start_q <= spi_start_d;
      uart_start_q <= uart_start_d;
    end
  end
  assign spi_tx_data = spi_data_q;
  assign spi_start = spi_start_q;
  assign uart_tx_data = uart_data_q;
  assign uart_tx_start = uart_start_q;
  assign fifo_count = cnt_q;
  assign overflow = ovf_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_uart_spi_bridge.sv
// tb_uart_spi_bridge: directed vector table plus hand-written corner sequences for uart_spi_bridge
module tb_uart_spi_bridge;
  logic clk = 0, reset = 0;
  logic [7:0] uart_rx_data = 0, spi_rx_data = 0;
  logic uart_rx_valid = 0, spi_tx_done = 0, hold = 0;
  logic [7:0] spi_tx_data, uart_tx_data;
  logic spi_start, uart_tx_start, uart_tx_ready, overflow, busy;
  logic [2:0] fifo_count;
  int checks = 0, failures = 0;
  int ucnt = 0, n_spi = 0, n_utx = 0, both_hi = 0, stab_err = 0;
  logic inflt = 0;
  logic [7:0] held = 0;
  logic [7:0] sent_q[$];

  typedef struct {
    logic [7:0] rx;
    logic [7:0] miso;
    int gap;
    logic [7:0] exp_spi;
    logic [7:0] exp_uart;
  } vec_t;
  vec_t v[4];

  always #5 clk = ~clk;
  assign uart_tx_ready = ucnt == 0 && !hold;

  uart_spi_bridge #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid),
    .spi_tx_data(spi_tx_data), .spi_start(spi_start),
    .spi_tx_done(spi_tx_done), .spi_rx_data(spi_rx_data),
    .uart_tx_data(uart_tx_data), .uart_tx_start(uart_tx_start),
    .uart_tx_ready(uart_tx_ready), .fifo_count(fifo_count),
    .overflow(overflow), .busy(busy)
  );

  // UART transmitter model (busy 4 cycles per start) and SPI-side monitors
  always @(posedge clk) begin
    if (uart_tx_start) ucnt <= 4;
    else if (ucnt != 0) ucnt <= ucnt - 1;
    if (spi_start) begin
      n_spi <= n_spi + 1;
      sent_q.push_back(spi_tx_data);
    end
    if (uart_tx_start) n_utx <= n_utx + 1;
    if (spi_start && uart_tx_start) both_hi <= both_hi + 1;
    if (!reset) inflt <= 0;
    else if (spi_start) begin
      inflt <= 1;
      held <= spi_tx_data;
    end else if (inflt) begin
      if (spi_tx_data != held) stab_err <= stab_err + 1;
      if (spi_tx_done) inflt <= 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    uart_rx_data = b;
    uart_rx_valid = 1;
    @(negedge clk);
    uart_rx_valid = 0;
  endtask

  task automatic done(input logic [7:0] miso);
    spi_rx_data = miso;
    spi_tx_done = 1;
    @(negedge clk);
    spi_tx_done = 0;
  endtask

  task automatic wait_start(input bit which, output int n);
    n = 0;
    while (!(which ? uart_tx_start : spi_start) && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", n < 300, 1);
  endtask

  task automatic serve(input logic [7:0] miso);
    int n = 0;
    while (!inflt && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("serve_inflight", n < 300, 1);
    tick(1);
    done(miso);
    wait_start(1, n);
    chk("serve_uart_data", uart_tx_data, miso);
    wait_idle();
  endtask

  task automatic do_reset();
    reset = 0;
    tick(2);
    reset = 1;
    tick(2);
  endtask

  initial begin
    int n, s0, u0;
    v[0] = '{8'hA5, 8'h3C, 18, 8'hA5, 8'h3C};
    v[1] = '{8'h00, 8'hFF, 1, 8'h00, 8'hFF};
    v[2] = '{8'hFF, 8'h00, 5, 8'hFF, 8'h00};
    v[3] = '{8'h5A, 8'hC3, 2, 8'h5A, 8'hC3};
    tick(3);
    chk("rst_spi_start", spi_start, 0);
    chk("rst_uart_start", uart_tx_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_spi_data", spi_tx_data, 8'h00);
    chk("rst_uart_data", uart_tx_data, 8'h00);
    reset = 1;
    tick(2);
    for (int i = 0; i < 4; i++) begin
      send(v[i].rx);
      wait_start(0, n);
      chk("vec_spi_latency", n + 1, 2);
      chk("vec_spi_data", spi_tx_data, v[i].exp_spi);
      chk("vec_busy", busy, 1);
      tick(v[i].gap);
      done(v[i].miso);
      wait_start(1, n);
      chk("vec_uart_latency", n + 1, 2);
      chk("vec_uart_data", uart_tx_data, v[i].exp_uart);
      wait_idle();
      tick(4);
    end
    s0 = n_spi;
    u0 = n_utx;
    done(8'hEE);
    tick(4);
    chk("spur_idle_uart_data", uart_tx_data, 8'hC3);
    chk("spur_idle_busy", busy, 0);
    chk("spur_idle_utx", n_utx - u0, 0);
    chk("spur_idle_spi", n_spi - s0, 0);
    send(8'h66);
    wait_start(0, n);
    done(8'h77);
    tick(3);
    chk("spur_start_uart_data", uart_tx_data, 8'hC3);
    chk("spur_start_busy", busy, 1);
    chk("spur_start_utx", n_utx - u0, 0);
    done(8'h88);
    wait_start(1, n);
    chk("spur_after_latency", n + 1, 2);
    chk("spur_after_uart_data", uart_tx_data, 8'h88);
    wait_idle();
    tick(4);
    do_reset();
    sent_q.delete();
    for (int i = 1; i <= 6; i++) send(8'(i));
    chk("burst_overflow", overflow, 1);
    chk("burst_count", fifo_count, 4);
    for (int i = 0; i < 5; i++) serve(8'hB0 + 8'(i));
    tick(20);
    chk("burst_sent_n", sent_q.size(), 5);
    for (int i = 0; i < 5 && i < sent_q.size(); i++) chk("burst_order", sent_q[i], 8'(i + 1));
    chk("burst_drained", fifo_count, 0);
    chk("burst_overflow_sticky", overflow, 1);
    do_reset();
    sent_q.delete();
    for (int i = 0; i < 5; i++) send(8'h10 + 8'(i));
    chk("full_count", fifo_count, 4);
    chk("full_no_ovf", overflow, 0);
    serve(8'h20);
    chk("pushpop_pre_idle", busy, 0);
    send(8'h15);
    chk("pushpop_count", fifo_count, 4);
    chk("pushpop_no_ovf", overflow, 0);
    for (int i = 0; i < 5; i++) serve(8'h21 + 8'(i));
    tick(10);
    chk("pushpop_sent_n", sent_q.size(), 6);
    for (int i = 0; i < 6 && i < sent_q.size(); i++) chk("pushpop_order", sent_q[i], 8'h10 + 8'(i));
    tick(4);
    sent_q.delete();
    hold = 1;
    send(8'h42);
    wait_start(0, n);
    tick(1);
    done(8'h5E);
    s0 = n_spi;
    u0 = n_utx;
    for (int i = 0; i < 50; i++) begin
      if (i == 10) send(8'h43);
      else tick(1);
    end
    chk("bp_no_utx", n_utx - u0, 0);
    chk("bp_no_spi", n_spi - s0, 0);
    chk("bp_busy", busy, 1);
    chk("bp_queued", fifo_count, 1);
    hold = 0;
    wait_start(1, n);
    chk("bp_release_latency", n, 1);
    chk("bp_uart_data", uart_tx_data, 8'h5E);
    wait_idle();
    serve(8'h6F);
    chk("bp_second_byte", sent_q.size() == 2 ? sent_q[1] : 8'hxx, 8'h43);
    tick(4);
    sent_q.delete();
    for (int i = 0; i < 4; i++) send(8'hA1 + 8'(i));
    chk("mid_busy", busy, 1);
    chk("mid_queued", fifo_count, 3);
    reset = 0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_spi_data", spi_tx_data, 8'h00);
    chk("mid_rst_uart_data", uart_tx_data, 8'h00);
    chk("mid_rst_starts", {spi_start, uart_tx_start, overflow}, 3'b000);
    @(negedge clk);
    reset = 1;
    s0 = n_spi;
    tick(30);
    chk("mid_no_spi_after", n_spi - s0, 0);
    chk("mid_count_after", fifo_count, 0);
    send(8'h7E);
    wait_start(0, n);
    chk("mid_new_byte", spi_tx_data, 8'h7E);
    serve(8'h81);
    chk("never_both_starts", both_hi, 0);
    chk("spi_data_stable", stab_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_spi_bridge.md
UART_SPI_BRIDGE -- requirements
Module: uart_spi_bridge

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, depth of the UART-to-SPI byte FIFO; the value SHALL be a power of two and at least 2.
REQ-002 Port: clk  in  1  single clock; all state SHALL be on its rising edge.
REQ-003 Port: reset  in  1  reset, asynchronous and active-low.
REQ-004 Port: uart_rx_data  in  8  byte from the UART receiver; SHALL be valid only while uart_rx_valid=1.
REQ-005 Port: uart_rx_valid  in  1  one-cycle pulse per received byte.
REQ-006 Port: spi_tx_data  out  8  byte for the SPI master; SHALL be held stable from spi_start until spi_tx_done.
REQ-007 Port: spi_start  out  1  one-cycle pulse that launches one SPI byte transfer.
REQ-008 Port: spi_tx_done  in  1  one-cycle pulse marking the end of the SPI transfer.
REQ-009 Port: spi_rx_data  in  8  byte shifted in on MISO; SHALL be valid in the spi_tx_done cycle.
REQ-010 Port: uart_tx_data  out  8  byte for the UART transmitter; SHALL be held stable until the next capture.
REQ-011 Port: uart_tx_start  out  1  one-cycle pulse that requests a UART transmission.
REQ-012 Port: uart_tx_ready  in  1  high when the UART transmitter is idle.
REQ-013 Port: fifo_count  out  $clog2(FIFO_DEPTH)+1  number of bytes held in the FIFO.
REQ-014 Port: overflow  out  1  sticky flag: a received byte was dropped.
REQ-015 Port: busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-016 The FIFO SHALL write uart_rx_data when uart_rx_valid=1 and the FIFO is not full; data SHALL be written at the tail and read from the head, with pointers wrapping modulo FIFO_DEPTH.
REQ-017 A write attempted while full, with no pop in the same cycle, SHALL drop the byte, leave the FIFO unchanged, and set overflow=1 until reset.
REQ-018 A push and a pop in the same cycle SHALL both take effect, including when the FIFO is full; fifo_count SHALL then be unchanged.
REQ-019 The FSM states SHALL be IDLE, SPI_START, SPI_WAIT, UART_WAIT, UART_START and UART_DRAIN.
REQ-020 IDLE: if fifo_count>0, the FSM SHALL pop the head byte into spi_tx_data and go to SPI_START; otherwise it SHALL stay in IDLE.
REQ-021 SPI_START: spi_start SHALL be 1 for this single cycle; the next state SHALL be SPI_WAIT unconditionally; any spi_tx_done in this cycle SHALL be ignored.
REQ-022 SPI_WAIT: on spi_tx_done=1, the FSM SHALL capture spi_rx_data into uart_tx_data and go to UART_WAIT; spi_tx_done in any other state SHALL be ignored.
REQ-023 UART_WAIT: when uart_tx_ready=1, the FSM SHALL go to UART_START.
REQ-024 UART_START: uart_tx_start SHALL be 1 for this single cycle; the next state SHALL be UART_DRAIN.
REQ-025 UART_DRAIN: the FSM SHALL wait for uart_tx_ready=0, then go to IDLE.
REQ-026 spi_start and uart_tx_start SHALL be registered outputs and SHALL never be high in the same cycle.
REQ-027 Latency, empty FIFO and FSM in IDLE: uart_rx_valid in cycle N SHALL produce spi_start in cycle N+2.
REQ-028 Latency, uart_tx_ready already high: spi_tx_done in cycle M SHALL produce uart_tx_start in cycle M+2.
REQ-029 FIFO writes SHALL continue in every FSM state; only one byte at a time SHALL be in flight between FIFO pop and UART_DRAIN exit.

Reset
REQ-030 While reset=0, asynchronously: FSM=IDLE; FIFO pointers and fifo_count=0; spi_start=0; uart_tx_start=0; spi_tx_data=8'h00; uart_tx_data=8'h00; overflow=0; busy=0.
REQ-031 Reset asserted mid-transfer SHALL discard all FIFO contents and the in-flight byte; after release, no start pulse SHALL issue until a new uart_rx_valid arrives.

Verification
REQ-032 Single byte: rx 8'hA5 at cycle 10; model returns 8'h3C with done at cycle 30, ready=1 -> spi_start at cycle 12 with spi_tx_data=A5; uart_tx_start at cycle 32 with uart_tx_data=3C.
REQ-033 Burst: FIFO_DEPTH=4, 6 bytes 01..06 on back-to-back cycles while the SPI model stalls -> bytes 01..04 (or 01..05 if a pop overlaps) are sent in order; overflow=1; dropped bytes never appear on spi_tx_data.
REQ-034 Simultaneous push/pop: FIFO full and in IDLE, rx pulse in the pop cycle -> fifo_count stays 4, overflow stays 0.
REQ-035 Backpressure: uart_tx_ready held 0 for 50 cycles after spi_tx_done -> no uart_tx_start until ready rises; no second spi_start meanwhile.
REQ-036 Reset in SPI_WAIT with 3 bytes queued -> all outputs at reset values; fifo_count=0; no spi_start after release without new input.
REQ-037 Spurious spi_tx_done in IDLE and in SPI_START -> ignored; no capture into uart_tx_data; no state change.
